// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- 8-bit arithmetic/logic unit for a 2A03-style 6502 CPU core.
//
// The unit supports binary arithmetic only. Decimal mode is not supported.
// It computes the result combinationally and registers the result and all
// four flags once. Outputs therefore show the operation sampled on the
// previous rising edge of clk. A new operation is accepted every cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears the result and the flags
//   alu_a      operand A (accumulator/index side)
//   alu_b      operand B (data-bus side); ignored by SR and PASS
//   mode       operation select:
//                0 ADD, 1 AND, 2 OR, 3 EOR, 4 SR, 5 SUB, 6..31 PASS
//   carry_in   carry input (P[0])
//   alu_out    registered result
//   carry_out  registered C flag
//   overflow   registered V flag
//   zero       registered Z flag
//   sign       registered N flag
// ---------------------------------------------------------------------------
module alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] alu_a,
   input  logic [WIDTH-1:0] alu_b,
   input  logic [4:0]       mode,
   input  logic             carry_in,
   output logic [WIDTH-1:0] alu_out,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             sign
);

   localparam logic [4:0] MODE_ADD = 5'd0;
   localparam logic [4:0] MODE_AND = 5'd1;
   localparam logic [4:0] MODE_OR  = 5'd2;
   localparam logic [4:0] MODE_EOR = 5'd3;
   localparam logic [4:0] MODE_SR  = 5'd4;
   localparam logic [4:0] MODE_SUB = 5'd5;

   localparam int MSB = WIDTH - 1;

   // Bitwise operations, computed one bit at a time.
   logic [WIDTH-1:0] and_bits;
   logic [WIDTH-1:0] or_bits;
   logic [WIDTH-1:0] eor_bits;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
         assign and_bits[gi] = alu_a[gi] & alu_b[gi];
         assign or_bits[gi]  = alu_a[gi] | alu_b[gi];
         assign eor_bits[gi] = alu_a[gi] ^ alu_b[gi];
      end
   endgenerate

   // ADD and SUB use the same adder structure. SUB adds the one's complement
   // of B, so carry_in = 1 means "no borrow", matching 6502 SBC behaviour.
   logic [WIDTH:0] add_sum;
   logic [WIDTH:0] sub_sum;

   assign add_sum = {1'b0, alu_a} + {1'b0, alu_b}  + {{WIDTH{1'b0}}, carry_in};
   assign sub_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{WIDTH{1'b0}}, carry_in};

   logic [WIDTH-1:0] result_next;
   logic             carry_next;
   logic             overflow_next;

   always_comb begin
      result_next   = alu_a;
      carry_next    = 1'b0;
      overflow_next = 1'b0;
      unique case (mode)
         MODE_ADD: begin
            result_next   = add_sum[WIDTH-1:0];
            carry_next    = add_sum[WIDTH];
            // Signed overflow: operands have the same sign, result sign differs.
            overflow_next = (alu_a[MSB] == alu_b[MSB]) &&
                            (add_sum[MSB] != alu_a[MSB]);
         end
         MODE_SUB: begin
            result_next   = sub_sum[WIDTH-1:0];
            carry_next    = sub_sum[WIDTH];
            // Signed overflow: operands have different signs and the result
            // does not keep the sign of the minuend.
            overflow_next = (alu_a[MSB] != alu_b[MSB]) &&
                            (sub_sum[MSB] != alu_a[MSB]);
         end
         MODE_AND: result_next = and_bits;
         MODE_OR:  result_next = or_bits;
         MODE_EOR: result_next = eor_bits;
         MODE_SR: begin
            // Rotate right through carry. Driving carry_in = 0 gives LSR.
            result_next = {carry_in, alu_a[WIDTH-1:1]};
            carry_next  = alu_a[0];
         end
         default: begin
            // PASS for every undefined mode.
            result_next = alu_a;
         end
      endcase
   end

   logic [WIDTH-1:0] result_reg;
   logic             carry_reg;
   logic             overflow_reg;
   logic             zero_reg;
   logic             sign_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         result_reg   <= '0;
         carry_reg    <= 1'b0;
         overflow_reg <= 1'b0;
         zero_reg     <= 1'b0;
         sign_reg     <= 1'b0;
      end else begin
         result_reg   <= result_next;
         carry_reg    <= carry_next;
         overflow_reg <= overflow_next;
         zero_reg     <= (result_next == '0);
         sign_reg     <= result_next[MSB];
      end
   end

   assign alu_out   = result_reg;
   assign carry_out = carry_reg;
   assign overflow  = overflow_reg;
   assign zero      = zero_reg;
   assign sign      = sign_reg;

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- scoreboard testbench for alu.
//
// Each issued operation pushes its expected registered response into a queue.
// A monitor pops one entry per clock, just after the edge, and compares it
// with the outputs. The reference model uses plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_alu;

   logic       clk;
   logic       rst;
   logic [7:0] alu_a;
   logic [7:0] alu_b;
   logic [4:0] mode;
   logic       carry_in;
   logic [7:0] alu_out;
   logic       carry_out;
   logic       overflow;
   logic       zero;
   logic       sign;

   alu #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .mode      (mode),
      .carry_in  (carry_in),
      .alu_out   (alu_out),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero),
      .sign      (sign)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] out;
      logic       c;
      logic       v;
      logic       z;
      logic       n;
   } exp_t;

   exp_t  sb_q[$];
   string name_q[$];
   int    tests_run = 0;
   int    tests_failed = 0;

   // Reference model: computes the result from integer arithmetic and the
   // signed value of each operand.
   function automatic exp_t model(input int a, input int b, input int m, input int cin);
      exp_t e;
      int   r;
      int   c;
      int   v;
      int   sa;
      int   sb;
      int   s;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      c = 0;
      v = 0;
      case (m)
         0: begin
            s = a + b + cin;
            r = s % 256;
            c = (s > 255) ? 1 : 0;
            v = ((sa + sb + cin) > 127 || (sa + sb + cin) < -128) ? 1 : 0;
         end
         5: begin
            s = a + (255 - b) + cin;
            r = s % 256;
            c = (s > 255) ? 1 : 0;
            v = ((sa - sb - (1 - cin)) > 127 || (sa - sb - (1 - cin)) < -128) ? 1 : 0;
         end
         1: r = a & b;
         2: r = a | b;
         3: r = a ^ b;
         4: begin
            r = cin * 128 + a / 2;
            c = a % 2;
         end
         default: r = a;
      endcase
      e.out = 8'(r);
      e.c   = (c != 0);
      e.v   = (v != 0);
      e.z   = (r == 0);
      e.n   = (r >= 128);
      return e;
   endfunction

   // Issues one operation after the falling edge and records its expected
   // response. A reset cycle expects all outputs to be zero.
   task automatic issue(input string nm, input logic r, input logic [7:0] a,
                        input logic [7:0] b, input logic [4:0] m, input logic cin);
      exp_t e;
      @(negedge clk);
      rst      = r;
      alu_a    = a;
      alu_b    = b;
      mode     = m;
      carry_in = cin;
      if (r) e = '0;
      else   e = model(int'(a), int'(b), int'(m), int'(cin));
      sb_q.push_back(e);
      name_q.push_back(nm);
   endtask

   // Monitor: one result is due after each rising edge that follows an issue.
   always @(posedge clk) begin
      exp_t  e;
      exp_t  got;
      string nm;
      #1;
      if (sb_q.size() > 0) begin
         e  = sb_q.pop_front();
         nm = name_q.pop_front();
         got = {alu_out, carry_out, overflow, zero, sign};
         tests_run++;
         if (got !== e) begin
            tests_failed++;
            $display("FAIL %s: got out=%02h C=%b V=%b Z=%b N=%b, expected out=%02h C=%b V=%b Z=%b N=%b",
                     nm, got.out, got.c, got.v, got.z, got.n, e.out, e.c, e.v, e.z, e.n);
         end else begin
            $display("[TB] ok %s: out=%02h C=%b V=%b Z=%b N=%b",
                     nm, got.out, got.c, got.v, got.z, got.n);
         end
      end
   end

   initial begin
      int drain;
      rst      = 1'b1;
      alu_a    = 8'hFF;
      alu_b    = 8'hFF;
      mode     = 5'd0;
      carry_in = 1'b1;

      // Reset takes priority over the inputs, then the first result appears.
      issue("reset0",      1'b1, 8'hFF, 8'hFF, 5'd0, 1'b1);
      issue("reset1",      1'b1, 8'hFF, 8'hFF, 5'd0, 1'b1);
      issue("first_add",   1'b0, 8'hFF, 8'hFF, 5'd0, 1'b1);

      issue("add_50_50",   1'b0, 8'h50, 8'h50, 5'd0, 1'b0);
      issue("add_ff_01",   1'b0, 8'hFF, 8'h01, 5'd0, 1'b0);
      issue("add_7f_cin",  1'b0, 8'h7F, 8'h00, 5'd0, 1'b1);
      issue("sub_50_b0",   1'b0, 8'h50, 8'hB0, 5'd5, 1'b1);
      issue("sub_05_05",   1'b0, 8'h05, 8'h05, 5'd5, 1'b1);
      issue("sub_05_05_b", 1'b0, 8'h05, 8'h05, 5'd5, 1'b0);
      issue("and_f0_3c",   1'b0, 8'hF0, 8'h3C, 5'd1, 1'b1);
      issue("or_f0_3c",    1'b0, 8'hF0, 8'h3C, 5'd2, 1'b1);
      issue("eor_f0_3c",   1'b0, 8'hF0, 8'h3C, 5'd3, 1'b1);
      issue("and_zero",    1'b0, 8'hF0, 8'h0F, 5'd1, 1'b0);
      issue("sr_03_cin",   1'b0, 8'h03, 8'hAA, 5'd4, 1'b1);
      issue("sr_01",       1'b0, 8'h01, 8'hAA, 5'd4, 1'b0);

      // Back-to-back modes, followed by a reset in the middle of the stream.
      issue("b2b_add",     1'b0, 8'h12, 8'h34, 5'd0, 1'b0);
      issue("b2b_sub",     1'b0, 8'h34, 8'h12, 5'd5, 1'b1);
      issue("b2b_pass31",  1'b0, 8'h00, 8'hFF, 5'd31, 1'b1);
      issue("b2b_pass9",   1'b0, 8'h9C, 8'h00, 5'd9, 1'b1);
      issue("mid_reset",   1'b1, 8'hFF, 8'h01, 5'd0, 1'b0);
      issue("after_reset", 1'b0, 8'h80, 8'h80, 5'd0, 1'b0);

      // Randomized operations. Most use defined modes, and reset is occasional.
      for (int i = 0; i < 300; i++) begin
         logic [4:0] m;
         logic       r;
         m = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                         : 5'($urandom_range(0, 5));
         r = ($urandom_range(0, 24) == 0);
         issue($sformatf("rand%0d", i), r, 8'($urandom), 8'($urandom), m,
               1'($urandom));
      end

      // Drain the scoreboard with a bounded number of cycles.
      drain = 0;
      while (sb_q.size() > 0 && drain < 10) begin
         @(negedge clk);
         drain++;
      end
      if (sb_q.size() > 0) begin
         tests_run++;
         tests_failed++;
         $display("FAIL drain: got %0d pending results, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
